// File: rtl/multiphase_clk_gen.sv
// N-phase non-overlapping clock generator clocked from cfst, with run/halt/step
// control and a bit-time counter that produces word sync and word strobe.
module multiphase_clk_gen #(
  parameter int RING_LEN   = 8,
  parameter int NPH        = 2,
  parameter int PW         = 1,
  parameter int WORD_BITS  = 56,
  parameter int SYNC_START = 45,
  parameter int SYNC_LEN   = 10,
  localparam int SW = (RING_LEN  > 1) ? $clog2(RING_LEN)  : 1,
  localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1
) (
  input  logic           cfst,
  input  logic           rstb,
  input  logic           run,
  input  logic           step,
  output logic [NPH-1:0] ph,
  output logic [SW-1:0]  slot,
  output logic [BW-1:0]  bit_cnt,
  output logic           sync,
  output logic           word_strobe,
  output logic           running
);

  localparam int SPACING = RING_LEN / NPH;
  localparam logic [SW-1:0] SLOT_LAST = SW'(RING_LEN - 1);
  localparam logic [SW-1:0] SLOT_ZERO = {SW{1'b0}};
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};

  // A pulse wider than the phase spacing minus one would remove the dead slot.
  if (PW < 1 || PW > SPACING - 1) begin : g_bad_pw
    $error("multiphase_clk_gen: PW must satisfy 1 <= PW <= RING_LEN/NPH - 1");
  end
  if (SYNC_START + SYNC_LEN > WORD_BITS) begin : g_bad_sync
    $error("multiphase_clk_gen: sync window extends past the end of the word");
  end

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_slot, w_slot_nxt;
  logic [BW-1:0]   r_bit, w_bit_nxt;
  logic [NPH-1:0]  r_ph, w_ph_nxt;
  logic            r_sync, w_sync_nxt;
  logic            r_ws, w_ws_nxt;
  logic            r_running, w_active_nxt;
  logic            w_bit_end;

  function automatic logic f_ph_hit(input logic [SW-1:0] s, input int k);
    int lo;
    lo = k * SPACING;
    return (int'(s) >= lo) && (int'(s) <= lo + PW - 1);
  endfunction

  function automatic logic f_sync_hit(input logic [BW-1:0] b);
    return (int'(b) >= SYNC_START) && (int'(b) < SYNC_START + SYNC_LEN);
  endfunction

  assign w_bit_end = (r_slot == SLOT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HALT: begin
        if (run) begin
          w_state_nxt = ST_RUN;
        end else if (step) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      // Leaving RUN only at the bit-time boundary keeps every pulse full width.
      ST_RUN: begin
        if (w_bit_end && !run) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STEP: begin
        if (w_bit_end) begin
          w_state_nxt = run ? ST_RUN : ST_HALT;
        end else begin
          w_state_nxt = ST_STEP;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // Outputs are decoded from next-state values so the flops line up with slot.
  always_comb begin
    w_active_nxt = (w_state_nxt != ST_HALT);
    w_slot_nxt   = SLOT_LAST;
    w_bit_nxt    = r_bit;
    w_sync_nxt   = r_sync;
    w_ph_nxt     = {NPH{1'b0}};
    if (w_active_nxt) begin
      if (r_slot == SLOT_LAST) begin
        w_slot_nxt = SLOT_ZERO;
      end else begin
        w_slot_nxt = r_slot + SW'(1);
      end
      if (w_slot_nxt == SLOT_ZERO) begin
        w_bit_nxt = (r_bit == BIT_LAST) ? BIT_ZERO : r_bit + BW'(1);
      end else begin
        w_bit_nxt = r_bit;
      end
      w_sync_nxt = f_sync_hit(w_bit_nxt);
    end else begin
      w_slot_nxt = SLOT_LAST;
    end
    for (int k = 0; k < NPH; k++) begin
      w_ph_nxt[k] = w_active_nxt && f_ph_hit(w_slot_nxt, k);
    end
    w_ws_nxt = w_active_nxt && (w_slot_nxt == SLOT_ZERO) && (w_bit_nxt == BIT_ZERO);
  end

  always_ff @(posedge cfst or negedge rstb) begin
    if (!rstb) begin
      r_state   <= ST_HALT;
      r_slot    <= SLOT_LAST;
      r_bit     <= BIT_LAST;
      r_ph      <= {NPH{1'b0}};
      r_sync    <= 1'b0;
      r_ws      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_slot    <= w_slot_nxt;
      r_bit     <= w_bit_nxt;
      r_ph      <= w_ph_nxt;
      r_sync    <= w_sync_nxt;
      r_ws      <= w_ws_nxt;
      r_running <= w_active_nxt;
    end
  end

  assign ph          = r_ph;
  assign slot        = r_slot;
  assign bit_cnt     = r_bit;
  assign sync        = r_sync;
  assign word_strobe = r_ws;
  assign running     = r_running;

endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Bench for multiphase_clk_gen: default instance against a bit-time model,
// plus a 12-slot/3-phase instance against a literal phase table.
module tb_multiphase_clk_gen;
  localparam int RL = 8, NP = 2, PWD = 1, WB = 56, SS = 45, SL = 10, SP = RL / NP;

  logic cfst = 1'b0;
  logic rstb, run, step;
  logic [1:0] ph;
  logic [2:0] slot;
  logic [5:0] bit_cnt;
  logic sync, word_strobe, running;
  logic [2:0] ph2;
  logic [3:0] slot2;
  logic [5:0] bit2;
  logic sync2, ws2, running2;

  multiphase_clk_gen dut (
    .cfst(cfst), .rstb(rstb), .run(run), .step(step), .ph(ph), .slot(slot),
    .bit_cnt(bit_cnt), .sync(sync), .word_strobe(word_strobe), .running(running)
  );

  multiphase_clk_gen #(.RING_LEN(12), .NPH(3), .PW(2)) dut2 (
    .cfst(cfst), .rstb(rstb), .run(1'b1), .step(1'b0), .ph(ph2), .slot(slot2),
    .bit_cnt(bit2), .sync(sync2), .word_strobe(ws2), .running(running2)
  );

  always #5 cfst = ~cfst;

  int checks = 0, errors = 0;
  int m_mode, m_pos, m_bit, c2;   // m_mode: 0 halted, 1 free-run, 2 single bit
  logic m_sync;
  int exp_ph2 [12] = '{1, 1, 0, 0, 2, 2, 0, 0, 4, 4, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = RL - 1; m_bit = WB - 1; m_sync = 1'b0; c2 = 0;
  endtask

  // One cfst edge of the bit-time rules: a new bit time starts on leaving HALT
  // or at the end of a bit time when the generator stays active.
  task automatic model_update(input logic r, input logic s);
    bit newbit;
    newbit = 1'b0;
    if (m_mode == 0) begin
      if (r) m_mode = 1;
      else if (s) m_mode = 2;
      newbit = (m_mode != 0);
    end else if (m_pos == RL - 1) begin
      m_mode = r ? 1 : 0;
      newbit = (m_mode != 0);
    end else begin
      m_pos++;
    end
    if (newbit) begin
      m_pos  = 0;
      m_bit  = (m_bit + 1) % WB;
      m_sync = (m_bit >= SS) && (m_bit < SS + SL);
    end
  endtask

  function automatic logic [NP-1:0] exp_ph();
    logic [NP-1:0] e;
    e = '0;
    for (int k = 0; k < NP; k++)
      if (m_mode != 0 && m_pos / SP == k && m_pos % SP < PWD) e[k] = 1'b1;
    return e;
  endfunction

  task automatic cyc(input logic r, input logic s);
    run = r; step = s;
    @(posedge cfst);
    if (rstb) begin
      model_update(r, s);
      c2++;
    end
    @(negedge cfst);
  endtask

  always @(negedge cfst) begin
    chk("slot", slot, m_pos);
    chk("bit_cnt", bit_cnt, m_bit);
    chk("ph", ph, exp_ph());
    chk("sync", sync, m_sync);
    chk("word_strobe", word_strobe, (m_mode != 0 && m_pos == 0 && m_bit == 0));
    chk("running", running, (m_mode != 0));
    chk("ph_overlap", ($countones(ph) <= 1), 1);
    chk("slot2", slot2, (c2 == 0) ? 11 : (c2 - 1) % 12);
    chk("ph2", ph2, (c2 == 0) ? 0 : exp_ph2[(c2 - 1) % 12]);
  end

  initial begin
    int b0, p0, p1, last, sc, nws, n;
    rstb = 1'b0; run = 1'b0; step = 1'b0;
    model_reset();
    repeat (3) cyc(1'b0, 1'b0);
    chk("rst_slot", slot, 7);
    chk("rst_bit", bit_cnt, 55);
    chk("rst_ph", ph, 0);
    chk("rst_sync", sync, 0);
    chk("rst_running", running, 0);
    rstb = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    cyc(1'b1, 1'b0);
    chk("first_slot", slot, 0);
    chk("first_ph", ph, 2'b01);
    chk("first_ws", word_strobe, 1);
    chk("first_bit", bit_cnt, 0);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    chk("drop_slot4", slot, 4);
    chk("drop_ph1", ph, 2'b10);
    repeat (4) cyc(1'b0, 1'b0);
    chk("halt_running", running, 0);
    chk("halt_slot", slot, 7);
    chk("halt_bit", bit_cnt, 0);
    chk("halt_ph", ph, 0);
    cyc(1'b1, 1'b0);
    chk("resume_slot", slot, 0);
    chk("resume_bit", bit_cnt, 1);

    n = 0;
    while (m_mode != 0 && n < 20) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    chk("halt_reached", running, 0);

    b0 = m_bit; p0 = 0; p1 = 0;
    cyc(1'b0, 1'b1);
    chk("step_running", running, 1);
    p0 += ph[0]; p1 += ph[1];
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, (i == 3));
      p0 += ph[0]; p1 += ph[1];
    end
    cyc(1'b0, 1'b0);
    chk("step_ph0_pulses", p0, 1);
    chk("step_ph1_pulses", p1, 1);
    chk("step_halted", running, 0);
    chk("step_bit", bit_cnt, (b0 + 1) % WB);

    cyc(1'b1, 1'b1);
    chk("runstep_running", running, 1);
    chk("runstep_slot", slot, 0);

    last = -1; sc = 0; nws = 0;
    for (int i = 0; i < 3 * 448; i++) begin
      cyc(1'b1, 1'b0);
      if (word_strobe) begin
        if (last >= 0) begin
          chk("ws_period", i - last, 448);
          chk("sync_len", sc, 80);
        end
        last = i; sc = 0; nws++;
      end else begin
        sc += sync;
      end
    end
    chk("ws_seen", (nws >= 2), 1);

    for (int i = 0; i < 800; i++)
      cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 5) == 0));

    n = 0;
    while (!(m_mode != 0 && m_pos == 4) && n < 40) begin
      cyc(1'b1, 1'b0);
      n++;
    end
    chk("pre_rst_ph", ph, 2'b10);
    #2 rstb = 1'b0;
    #1;
    chk("async_ph", ph, 0);
    chk("async_slot", slot, 7);
    chk("async_bit", bit_cnt, 55);
    chk("async_sync", sync, 0);
    chk("async_running", running, 0);
    model_reset();
    cyc(1'b0, 1'b0);
    rstb = 1'b1;
    cyc(1'b1, 1'b0);
    chk("restart_slot", slot, 0);
    chk("restart_bit", bit_cnt, 0);
    chk("restart_ws", word_strobe, 1);
    repeat (30) cyc(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiphase_clk_gen.md
Name: multiphase_clk_gen

Overview:
- Parametrised, glitch-free N-phase non-overlapping clock generator for the calculator chipset (ARC, ROM, CTC), driven from the fast system clock cfst.
- Generalises the fixed 2-phase one-hot divider: configurable ring length, phase count and pulse width.
- Adds run/halt/single-step control and a bit-time counter that produces word sync and word strobe.
- Every phase output comes directly from a flop, so no decode spikes reach the chip models.

Parameters:
RING_LEN, 8, cfst cycles per bit time (slots 0..RING_LEN-1)
NPH, 2, number of phase outputs
PW, 1, phase pulse width in slots; legal only if PW <= RING_LEN/NPH - 1 (elaboration error otherwise)
WORD_BITS, 56, bit times per word
SYNC_START, 45, first bit time with sync high
SYNC_LEN, 10, bit times sync stays high; SYNC_START+SYNC_LEN <= WORD_BITS

Ports:
cfst  input  1  fast clock, all state on rising edge
rstb  input  1  reset, asynchronous, active-low
run  input  1  level; 1 = free-run phases
step  input  1  one-cfst pulse; requests one bit time while halted
ph  output  NPH  phase clocks, ph[0] = first phase
slot  output  clog2(RING_LEN)  current slot index
bit_cnt  output  clog2(WORD_BITS)  current bit time in word
sync  output  1  high during bit times SYNC_START..SYNC_START+SYNC_LEN-1
word_strobe  output  1  one cfst cycle high at slot 0 of bit 0
running  output  1  1 in RUN or STEP state

Behaviour:
- Reset (async, rstb=0):
  - state=HALT, slot=RING_LEN-1, bit_cnt=WORD_BITS-1.
  - ph=0, sync=0, word_strobe=0, running=0.
  - Outputs go low immediately, including mid-pulse.
- States: HALT, RUN, STEP.
- HALT:
  - slot parked at RING_LEN-1; ph forced 0; bit_cnt held.
  - run=1 -> RUN.
  - run=0 and step=1 -> STEP.
  - run and step together: run wins; step is discarded.
- RUN/STEP slot advance:
  - slot increments by 1 each cfst and wraps RING_LEN-1 -> 0.
  - Entering from HALT, the first active cycle is slot 0.
- Exit at end of bit time (edge where slot==RING_LEN-1):
  - RUN with run=0 -> HALT; the current bit time always completes, so there are no truncated pulses.
  - STEP -> RUN if run=1, else HALT.
  - step during RUN/STEP is ignored and not queued.
- Phase decode:
  - ph[k]=1 iff state!=HALT and k*(RING_LEN/NPH) <= slot <= k*(RING_LEN/NPH)+PW-1.
  - Registered from next-state/next-slot so ph is aligned with slot.
  - Any two phases are never high in the same cycle; at least one dead slot lies between consecutive phases.
- bit_cnt:
  - Increments on every transition into slot 0 (including the first from HALT).
  - Wraps WORD_BITS-1 -> 0; frozen in HALT.
- sync:
  - Registered decode of next bit_cnt; constant across a whole bit time.
  - Holds its value in HALT, except after reset, when it is 0.
- word_strobe = (slot==0 and bit_cnt==0 and state!=HALT); high for exactly one cfst cycle per word.
- running mirrors state!=HALT, registered.
- Widths: slot/bit_cnt use clog2 with a minimum of 1; wrap uses explicit compare, not power-of-two overflow.

Test Plan:
- Defaults, reset then run=1 held -> slot 0 ph=2'b01, slot 4 ph=2'b10, else 0. Period 8 cfst. Never ph==2'b11. First bit_cnt=0 with word_strobe=1.
- run dropped at slot 2 -> ph[1] still pulses at slot 4; after slot 7, HALT: slot=7, ph=0, running=0, bit_cnt unchanged. Re-asserting run resumes at slot 0, bit_cnt+1.
- Halted, step pulse (run=0) -> exactly one ph[0] and one ph[1] pulse over 8 cfst, bit_cnt+1, back to HALT. Second step during that bit time is ignored. run+step together -> free-run.
- Free-run 2 words -> word_strobe every 448 cfst. sync high for bit_cnt 45..54 (80 cfst), low at 55 and 0..44. bit_cnt wraps 55->0.
- rstb low at slot 4 while ph[1]=1 -> ph=0 within the same cycle (async). slot=7, bit_cnt=55, sync=0. After release with run=1, restart at slot 0, bit 0.
- RING_LEN=12, NPH=3, PW=2 -> ph[0] slots 0-1, ph[1] 4-5, ph[2] 8-9, period 12. PW=4 with these values -> elaboration error.
